// File: rtl/mc_alu.sv
// rtl/mc_alu.sv - multi-cycle ALU: AND/OR/ADD/SUB in one cycle, shift-add MUL, restoring DIVU.
// DIVU and the DIV state are built only when MC_ALU_DIV_EN is defined; otherwise 1001 is illegal.
module mc_alu #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [3:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             err
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam int         CW      = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] a_q, b_q, acc_q;
  logic [CW-1:0]    cnt_q;
  logic             last, is_div;
  logic [WIDTH:0]   add_full, sub_full;
  logic [WIDTH-1:0] mul_acc_n;
  logic [WIDTH-1:0] imm_res;
  logic             imm_cout, imm_err;
  logic [WIDTH-1:0] result_q;
  logic             cout_q, zero_q, err_q;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign result    = result_q;
  assign cout      = cout_q;
  assign zero      = zero_q;
  assign err       = err_q;

  assign last      = (cnt_q == CW'(WIDTH - 1));
  assign add_full  = {1'b0, x} + {1'b0, y};
  assign sub_full  = {1'b0, x} + {1'b0, ~y} + {{WIDTH{1'b0}}, 1'b1};
  // a_q is the multiplicand shifted left, b_q the multiplier shifted right.
  assign mul_acc_n = acc_q + (b_q[0] ? a_q : '0);

`ifdef MC_ALU_DIV_EN
  // Division reuses a_q as the dividend/quotient shifter and acc_q as the partial remainder.
  logic [WIDTH:0]   rem_sh, rem_diff;
  logic [WIDTH-1:0] rem_n, quo_n;

  assign is_div   = (alu_control == OP_DIVU);
  assign rem_sh   = {acc_q, a_q[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, b_q};

  always_comb begin
    rem_n = rem_diff[WIDTH-1:0];
    quo_n = {a_q[WIDTH-2:0], 1'b1};
    if (rem_diff[WIDTH]) begin
      rem_n = rem_sh[WIDTH-1:0];
      quo_n = {a_q[WIDTH-2:0], 1'b0};
    end
  end
`else
  assign is_div = 1'b0;
`endif

  // Single-cycle results; anything not decoded here falls through as illegal.
  always_comb begin
    imm_res  = '0;
    imm_cout = 1'b0;
    imm_err  = 1'b1;
    case (alu_control)
      OP_AND: begin imm_res = x & y; imm_err = 1'b0; end
      OP_OR:  begin imm_res = x | y; imm_err = 1'b0; end
      OP_ADD: begin imm_res = add_full[WIDTH-1:0]; imm_cout = add_full[WIDTH]; imm_err = 1'b0; end
      OP_SUB: begin imm_res = sub_full[WIDTH-1:0]; imm_cout = sub_full[WIDTH]; imm_err = 1'b0; end
`ifdef MC_ALU_DIV_EN
      OP_DIVU: begin imm_res = '1; imm_err = 1'b0; end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          if (alu_control == OP_MUL)    state_n = S_MUL;
          else if (is_div && y != '0)   state_n = S_DIV;
          else                          state_n = S_DONE;
        end
      end
      S_MUL:   if (last) state_n = S_DONE;
      S_DIV:   if (last) state_n = S_DONE;
      S_DONE:  if (out_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q   <= x;
            b_q   <= y;
            acc_q <= '0;
            cnt_q <= '0;
            if (state_n == S_DONE) begin
              result_q <= imm_res;
              cout_q   <= imm_cout;
              err_q    <= imm_err;
              zero_q   <= (imm_res == '0);
            end
          end
        end
        S_MUL: begin
          acc_q <= mul_acc_n;
          a_q   <= a_q << 1;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            result_q <= mul_acc_n;
            cout_q   <= 1'b0;
            err_q    <= 1'b0;
            zero_q   <= (mul_acc_n == '0);
          end
        end
`ifdef MC_ALU_DIV_EN
        S_DIV: begin
          acc_q <= rem_n;
          a_q   <= quo_n;
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            result_q <= quo_n;
            cout_q   <= 1'b0;
            err_q    <= 1'b0;
            zero_q   <= (quo_n == '0);
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mc_alu.md
MC_ALU -- requirements
Module: mc_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 64: operand/result width, any value >= 8.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operation request.
REQ-005 SHALL have port in_ready  output  1  high exactly when state is IDLE.
REQ-006 SHALL have port x  input  WIDTH  operand A.
REQ-007 SHALL have port y  input  WIDTH  operand B.
REQ-008 SHALL have port alu_control  input  4  opcode: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1000 MUL, 1001 DIVU.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port result  output  WIDTH  operation result.
REQ-012 SHALL have port cout  output  1  carry out (ADD/SUB only).
REQ-013 SHALL have port zero  output  1  result == 0.
REQ-014 SHALL have port err  output  1  illegal or unsupported opcode.

Function
REQ-015 SHALL implement states IDLE, MUL, DIV, DONE.
REQ-016 Accept SHALL occur on a rising edge with in_valid && in_ready; x, y, alu_control latched at accept; later input changes ignored.
REQ-017 AND/OR/ADD/SUB/illegal: IDLE -> DONE at accept; out_valid high the next cycle (latency 1).
REQ-018 ADD: result = (x+y) mod 2^WIDTH, cout = carry out of bit WIDTH-1.
REQ-019 SUB: result = x+~y+1 mod 2^WIDTH, cout = 1 iff x >= y unsigned (no borrow).
REQ-020 cout SHALL be 0 for all opcodes other than ADD/SUB.
REQ-021 MUL: IDLE -> MUL; shift-add, one multiplier bit per cycle, exactly WIDTH cycles in MUL, then DONE; result = low WIDTH bits of unsigned product; out_valid WIDTH+1 cycles after accept.
REQ-022 DIVU: IDLE -> DIV; restoring division, one quotient bit per cycle, exactly WIDTH cycles, then DONE; result = unsigned quotient floor(x/y).
REQ-023 DIVU with y == 0: SHALL skip DIV, go to DONE at accept, result = all-ones, err = 0.
REQ-024 Illegal opcode: result = 0, err = 1, zero = 1.
REQ-025 zero SHALL equal (result == 0) whenever out_valid is high.
REQ-026 DONE: out_valid = 1; result/cout/zero/err held stable until out_ready sampled high; then DONE -> IDLE, out_valid low next cycle.
REQ-027 No new request SHALL be accepted in MUL, DIV or DONE (in_ready = 0); back-to-back operations separated by at least one IDLE cycle.
REQ-028 out_ready while out_valid is low SHALL have no effect.

Reset
REQ-029 rst_n low at a rising edge SHALL force IDLE, out_valid = 0, result = 0, cout = 0, zero = 0, err = 0, clearing all iteration registers, in any state including mid-MUL/DIV.
REQ-030 An in_valid present on the same edge as reset SHALL be discarded; in_ready high from the first cycle after reset.

Configuration
REQ-031 Macro MC_ALU_DIV_EN defined: DIVU and DIV state implemented per REQ-022/023.
REQ-032 Macro MC_ALU_DIV_EN undefined: no divider logic; opcode 1001 treated as illegal per REQ-024 (latency 1, err = 1).

Verification
REQ-033 WIDTH=64, ADD x=1 y=0 -> result 1, cout 0, zero 0, out_valid one cycle after accept.
REQ-034 SUB x=6 y=3 -> result 3, cout 1; SUB x=3 y=6 -> result 0xFFFFFFFFFFFFFFFD, cout 0; AND x=6 y=1 -> result 0, zero 1; OR x=6 y=3 -> result 7.
REQ-035 MUL x=6 y=3 -> result 18, out_valid exactly 65 cycles after accept; MUL x=2^63 y=2 -> result 0, zero 1.
REQ-036 DIVU x=7 y=2 -> result 3 after 65 cycles; DIVU y=0 -> all-ones after 1 cycle; with MC_ALU_DIV_EN undefined DIVU -> result 0, err 1.
REQ-037 Hold out_ready low 5 cycles in DONE -> result stable, in_ready 0, in_valid ignored; out_ready high -> IDLE next cycle.
REQ-038 Assert rst_n low at cycle 10 of MUL -> all outputs 0 next cycle, in_ready 1; subsequent ADD 1+1 -> result 2.
